// File: rtl/as_upstream_wrr_arb.sv
// as_upstream_wrr_arb
// Packet-aware weighted round-robin arbiter that shares the upstream IO-Serdes channel
// among three AXI-Stream sources (0 = user project, 1 = axilite-axis bridge,
// 2 = logic analyzer). A grant is held until the packet ends or, for normal-priority
// grants, until the burst cap latched at grant time is reached.
//
// Ports:
//   i_axis_clk     clock
//   i_axi_reset_n  asynchronous active-low reset
//   i_req          per-source tvalid
//   i_hi_req       per-source high-priority request (masked by HI_MASK)
//   i_beat         handshake on the granted stream
//   i_last         tlast of the granted stream, qualified by i_beat
//   i_cfg_we       register write strobe
//   i_cfg_addr     register word address (0 weights, 1 burst_max, 2 enable)
//   i_cfg_wdata    register write data
//   o_cfg_rdata    combinational read of the register at i_cfg_addr
//   o_grant        one-hot registered grant, 0 when idle
//   o_grant_id     encoded grant, 0 when idle
//   o_grant_hi     current grant was won at high priority
module as_upstream_wrr_arb #(
    parameter int unsigned  N         = 3,
    parameter logic [N-1:0] HI_MASK   = 3'b101,
    parameter logic [3:0]   BURST_RST = 4'd8
) (
    input  logic         i_axis_clk,
    input  logic         i_axi_reset_n,
    input  logic [N-1:0] i_req,
    input  logic [N-1:0] i_hi_req,
    input  logic         i_beat,
    input  logic         i_last,
    input  logic         i_cfg_we,
    input  logic [1:0]   i_cfg_addr,
    input  logic [11:0]  i_cfg_wdata,
    output logic [11:0]  o_cfg_rdata,
    output logic [N-1:0] o_grant,
    output logic [1:0]   o_grant_id,
    output logic         o_grant_hi
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [11:0]         r_weights;
    logic [3:0]          r_burst_max;
    logic [N-1:0]        r_enable;
    logic [N-1:0][3:0]   r_credit;
    logic [1:0]          r_ptr;
    logic [4:0]          r_bcnt;
    logic [4:0]          r_cap;
    logic [N-1:0]        r_grant;
    logic [1:0]          r_grant_id;
    logic                r_grant_hi;

    logic [N-1:0]        w_req_en;
    logic [N-1:0]        w_cred_nz;
    logic [N-1:0]        w_e_hi;
    logic [N-1:0]        w_e_lo;
    logic [1:0]          w_win;
    logic [N-1:0]        w_win_oh;
    logic                w_idle;
    logic                w_take;
    logic                w_take_hi;
    logic                w_replenish;
    logic                w_release;
    logic [4:0]          w_bcnt_inc;

    // First set bit of mask in the order ptr+1, ptr+2, ptr (mod N).
    // Iterating backwards lets the earliest position in that order win.
    function automatic logic [1:0] f_pick(input logic [N-1:0] mask, input logic [1:0] ptr);
        logic [1:0] win;
        int         t;
        win = 2'd0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            t = (int'(ptr) + k + 1) % int'(N);
            if (mask[t]) win = 2'(t);
        end
        return win;
    endfunction

    // A programmed weight of 0 behaves as 1.
    function automatic logic [3:0] f_eff_weight(input logic [3:0] w);
        return (w == 4'd0) ? 4'd1 : w;
    endfunction

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            w_cred_nz[i] = (r_credit[i] != 4'd0);
        end
    end

    assign w_req_en    = i_req & r_enable;
    assign w_e_hi      = i_hi_req & HI_MASK & w_req_en;
    assign w_e_lo      = w_req_en & w_cred_nz;
    assign w_win       = f_pick((|w_e_hi) ? w_e_hi : w_e_lo, r_ptr);
    assign w_win_oh    = {{(N-1){1'b0}}, 1'b1} << w_win;
    assign w_idle      = (r_state == StIdle);
    assign w_take      = w_idle & ((|w_e_hi) | (|w_e_lo));
    assign w_take_hi   = w_idle & (|w_e_hi);
    // Requests exist but every eligible source is out of credit: refill and retry.
    assign w_replenish = w_idle & ~(|w_e_hi) & ~(|w_e_lo) & (|w_req_en);
    assign w_bcnt_inc  = r_bcnt + 5'd1;
    // High-priority grants ignore the cap; a last on the cap beat is still one release.
    assign w_release   = (r_state == StGrant) & i_beat &
                         (i_last | (~r_grant_hi & (w_bcnt_inc == r_cap)));

    // State register
    always_ff @(posedge i_axis_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_take)    w_state_d = StGrant;
            StGrant: if (w_release) w_state_d = StIdle;
        endcase
    end

    // Grant, credit, counter and configuration registers
    always_ff @(posedge i_axis_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            r_weights   <= 12'h111;
            r_burst_max <= BURST_RST;
            r_enable    <= {N{1'b1}};
            r_credit    <= {N{4'd1}};
            r_ptr       <= 2'd0;
            r_bcnt      <= 5'd0;
            r_cap       <= 5'd0;
            r_grant     <= '0;
            r_grant_id  <= 2'd0;
            r_grant_hi  <= 1'b0;
        end else begin
            if (w_take) begin
                r_ptr      <= w_win;
                r_bcnt     <= 5'd0;
                r_cap      <= {r_burst_max == 4'd0, r_burst_max};
                r_grant    <= w_win_oh;
                r_grant_id <= w_win;
                r_grant_hi <= w_take_hi;
            end else if (r_state == StGrant && i_beat) begin
                r_bcnt <= w_bcnt_inc;
                if (w_release) begin
                    r_grant    <= '0;
                    r_grant_id <= 2'd0;
                    r_grant_hi <= 1'b0;
                end
            end

            if (w_replenish) begin
                for (int i = 0; i < int'(N); i++) begin
                    r_credit[i] <= f_eff_weight(r_weights[4*i +: 4]);
                end
            end else if (w_take && !w_take_hi && r_credit[w_win] != 4'd0) begin
                r_credit[w_win] <= r_credit[w_win] - 4'd1;
            end

            // Arbitration above used the pre-write values.
            if (i_cfg_we) begin
                unique case (i_cfg_addr)
                    2'd0:    r_weights   <= i_cfg_wdata;
                    2'd1:    r_burst_max <= i_cfg_wdata[3:0];
                    2'd2:    r_enable    <= i_cfg_wdata[N-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Outputs
    always_comb begin
        o_grant    = r_grant;
        o_grant_id = r_grant_id;
        o_grant_hi = r_grant_hi;
        unique case (i_cfg_addr)
            2'd0:    o_cfg_rdata = r_weights;
            2'd1:    o_cfg_rdata = {8'h00, r_burst_max};
            2'd2:    o_cfg_rdata = {{(12-N){1'b0}}, r_enable};
            default: o_cfg_rdata = 12'h000;
        endcase
    end

endmodule

// File: tb/tb_as_upstream_wrr_arb.sv
module tb_as_upstream_wrr_arb;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  hi_req;
    logic        beat;
    logic        last;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [11:0] cfg_wdata;
    logic [11:0] cfg_rdata;
    logic [2:0]  grant;
    logic [1:0]  grant_id;
    logic        grant_hi;

    int n_cmp;
    int n_err;

    as_upstream_wrr_arb dut (
        .i_axis_clk    (clk),
        .i_axi_reset_n (rst_n),
        .i_req         (req),
        .i_hi_req      (hi_req),
        .i_beat        (beat),
        .i_last        (last),
        .i_cfg_we      (cfg_we),
        .i_cfg_addr    (cfg_addr),
        .i_cfg_wdata   (cfg_wdata),
        .o_cfg_rdata   (cfg_rdata),
        .o_grant       (grant),
        .o_grant_id    (grant_id),
        .o_grant_hi    (grant_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_g;        // granted source, -1 when idle
    bit m_hi;
    int m_beats;
    int m_cap;
    int m_cred[3];
    int m_ptr;
    int m_w[3];
    int m_bm;
    bit [2:0] m_en;

    function automatic void m_reset();
        m_g = -1; m_hi = 0; m_beats = 0; m_cap = 0; m_ptr = 0;
        for (int i = 0; i < 3; i++) begin m_cred[i] = 1; m_w[i] = 1; end
        m_bm = 8; m_en = 3'b111;
    endfunction

    function automatic int m_read(input logic [1:0] a);
        case (a)
            2'd0:    return (m_w[2] << 8) | (m_w[1] << 4) | m_w[0];
            2'd1:    return m_bm;
            2'd2:    return int'(m_en);
            default: return 0;
        endcase
    endfunction

    // One clock edge of the arbiter, from the rules: who may win, who wins, when it ends.
    function automatic void m_step();
        bit [2:0] elig_hi, elig_lo, active;
        int win;
        active = req & m_en;
        elig_hi = hi_req & 3'b101 & active;
        elig_lo = 3'b000;
        for (int i = 0; i < 3; i++) if (active[i] && m_cred[i] > 0) elig_lo[i] = 1'b1;
        win = -1;
        if (m_g < 0) begin
            if (elig_hi != 0) begin
                for (int k = 1; k <= 3; k++) if (win < 0 && elig_hi[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
                m_hi = 1;
            end else if (elig_lo != 0) begin
                for (int k = 1; k <= 3; k++) if (win < 0 && elig_lo[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
                m_cred[win] = m_cred[win] - 1;
                m_hi = 0;
            end else if (active != 0) begin
                for (int i = 0; i < 3; i++) m_cred[i] = (m_w[i] == 0) ? 1 : m_w[i];
            end
            if (win >= 0) begin
                m_g = win; m_ptr = win; m_beats = 0;
                m_cap = (m_bm == 0) ? 16 : m_bm;
            end
        end else if (beat) begin
            m_beats++;
            if (last || (!m_hi && m_beats == m_cap)) begin m_g = -1; m_hi = 0; end
        end
        if (cfg_we) begin
            case (cfg_addr)
                2'd0: for (int i = 0; i < 3; i++) m_w[i] = int'((cfg_wdata >> (4 * i)) & 12'hF);
                2'd1: m_bm = int'(cfg_wdata[3:0]);
                2'd2: m_en = cfg_wdata[2:0];
                default: ;
            endcase
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic cmp_out(input string nm, input logic [2:0] eg, input logic [1:0] eid,
                           input logic ehi);
        n_cmp++;
        if (grant !== eg || grant_id !== eid || grant_hi !== ehi) begin
            n_err++;
            $display("FAIL %s: got grant=%b id=%0d hi=%b, expected grant=%b id=%0d hi=%b",
                     nm, grant, grant_id, grant_hi, eg, eid, ehi);
        end
    endtask

    task automatic cmp_model(input string nm);
        logic [2:0] eg;
        logic [1:0] eid;
        eg  = (m_g < 0) ? 3'b000 : (3'b001 << m_g);
        eid = (m_g < 0) ? 2'd0 : 2'(m_g);
        cmp_out(nm, eg, eid, m_hi);
    endtask

    task automatic cmp_val(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step(input bit chk, input string nm);
        #1;
        if (chk) cmp_val({nm, "_rdata"}, int'(cfg_rdata), m_read(cfg_addr));
        m_step();
        @(posedge clk);
        #1;
        if (chk) cmp_model(nm);
    endtask

    task automatic idle_inputs();
        req = 3'b000; hi_req = 3'b000; beat = 1'b0; last = 1'b0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 12'h000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
    endtask

    typedef struct {
        logic [2:0] req;
        logic [2:0] hi;
        logic       beat;
        logic       last;
        logic [2:0] eg;
        logic [1:0] eid;
        logic       ehi;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int cnt[3];
        int dbl_idle;
        logic [2:0] prev;
        int run;
        int bursts;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_inputs();

        // Default weights, 1-beat packets: 1,2,0 then a refill cycle, then 1,2,0 again.
        tbl[0]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b010, 2'd1, 1'b0};
        tbl[1]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0};
        tbl[2]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b100, 2'd2, 1'b0};
        tbl[3]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0};
        tbl[4]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b001, 2'd0, 1'b0};
        tbl[5]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0};
        tbl[6]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0};
        tbl[7]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b010, 2'd1, 1'b0};
        tbl[8]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0};
        tbl[9]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b100, 2'd2, 1'b0};
        tbl[10] = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0};
        tbl[11] = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b001, 2'd0, 1'b0};

        // ---- reset state ----
        do_reset();
        cmp_out("reset_outputs", 3'b000, 2'd0, 1'b0);
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            #1;
            cmp_val("reset_rdata", int'(cfg_rdata), m_read(cfg_addr));
        end
        cfg_addr = 2'd0;

        // ---- table: round robin with 1-beat packets ----
        for (int i = 0; i < 12; i++) begin
            req = tbl[i].req; hi_req = tbl[i].hi; beat = tbl[i].beat; last = tbl[i].last;
            step(1'b0, "tbl");
            cmp_out($sformatf("rr_tbl[%0d]", i), tbl[i].eg, tbl[i].eid, tbl[i].ehi);
        end

        // ---- weights 1,3,1 ----
        do_reset();
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 12'h131;
        step(1'b1, "wt_write");
        cfg_we = 1'b0;
        req = 3'b111; beat = 1'b1; last = 1'b1;
        cnt = '{0, 0, 0};
        dbl_idle = 0;
        prev = 3'b000;
        for (int c = 0; c < 28; c++) begin
            step(1'b1, "wrr");
            if (grant != 3'b000 && prev == 3'b000) begin
                for (int s = 0; s < 3; s++) if (grant[s]) cnt[s]++;
            end
            if (grant == 3'b000 && prev == 3'b000) dbl_idle++;
            prev = grant;
        end
        cmp_val("wrr_src0", cnt[0], 3);
        cmp_val("wrr_src1", cnt[1], 7);
        cmp_val("wrr_src2", cnt[2], 3);
        cmp_val("wrr_replenish", dbl_idle, 2);

        // ---- burst cap 8 on a long source-1 stream ----
        do_reset();
        req = 3'b111; beat = 1'b1;
        run = 0;
        bursts = 0;
        for (int c = 0; c < 60; c++) begin
            last = (m_g >= 0 && m_g != 1);
            step(1'b1, "burst");
            if (grant == 3'b010) run++;
            else begin
                if (run > 0) begin
                    bursts++;
                    cmp_val("burst_len", run, 8);
                end
                run = 0;
            end
        end
        cmp_val("burst_rounds", int'(bursts >= 3), 1);

        // ---- high priority waits for packet end, then ignores the cap ----
        do_reset();
        req = 3'b001; beat = 1'b0; last = 1'b0;
        step(1'b1, "hi_setup");
        cmp_out("hi_lo_grant", 3'b001, 2'd0, 1'b0);
        req = 3'b101; hi_req = 3'b100;
        step(1'b1, "hi_wait");
        step(1'b1, "hi_wait");
        cmp_out("hi_no_preempt", 3'b001, 2'd0, 1'b0);
        beat = 1'b1; last = 1'b1;
        step(1'b1, "hi_release");
        cmp_out("hi_lo_released", 3'b000, 2'd0, 1'b0);
        beat = 1'b0; last = 1'b0;
        step(1'b1, "hi_grant");
        cmp_out("hi_granted", 3'b100, 2'd2, 1'b1);
        for (int b = 1; b <= 20; b++) begin
            beat = 1'b1; last = (b == 20);
            step(1'b1, "hi_pkt");
            if (b == 19) cmp_out("hi_past_cap", 3'b100, 2'd2, 1'b1);
        end
        cmp_out("hi_pkt_end", 3'b000, 2'd0, 1'b0);
        idle_inputs();
        step(1'b1, "hi_idle");

        // ---- enable mask ----
        do_reset();
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 12'h005;
        step(1'b1, "en_write");
        cfg_we = 1'b0; req = 3'b010;
        for (int c = 0; c < 4; c++) step(1'b1, "en_masked");
        cmp_out("en_masked_none", 3'b000, 2'd0, 1'b0);
        cfg_we = 1'b1; cfg_wdata = 12'h007;
        step(1'b1, "en_reenable");
        cmp_out("en_write_cycle", 3'b000, 2'd0, 1'b0);
        cfg_we = 1'b0;
        step(1'b1, "en_grant");
        cmp_out("en_grant_src1", 3'b010, 2'd1, 1'b0);
        #1;
        cmp_val("en_rdata", int'(cfg_rdata), 7);

        // ---- randomized against the model ----
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req       = 3'($urandom);
            hi_req    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            beat      = ($urandom_range(0, 3) != 0);
            last      = ($urandom_range(0, 5) == 0);
            cfg_we    = ($urandom_range(0, 24) == 0);
            cfg_addr  = 2'($urandom);
            cfg_wdata = 12'($urandom);
            if (cfg_we && cfg_addr == 2'd2 && cfg_wdata[2:0] == 3'b000) cfg_wdata[0] = 1'b1;
            step(1'b1, "rand");
        end

        // ---- asynchronous reset mid-packet ----
        idle_inputs();
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 12'hABC;
        step(1'b1, "rst_cfg");
        cfg_addr = 2'd1; cfg_wdata = 12'h003;
        step(1'b1, "rst_cfg");
        cfg_addr = 2'd2; cfg_wdata = 12'h003;
        step(1'b1, "rst_cfg");
        cfg_we = 1'b0; req = 3'b011;
        step(1'b1, "rst_grant");
        step(1'b1, "rst_grant");
        cmp_val("rst_pre_granted", int'(grant != 3'b000), 1);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        cmp_out("rst_async_clear", 3'b000, 2'd0, 1'b0);
        cfg_addr = 2'd0; #1; cmp_val("rst_rdata0", int'(cfg_rdata), 12'h111);
        cfg_addr = 2'd1; #1; cmp_val("rst_rdata1", int'(cfg_rdata), 12'h008);
        cfg_addr = 2'd2; #1; cmp_val("rst_rdata2", int'(cfg_rdata), 12'h007);
        cfg_addr = 2'd3; #1; cmp_val("rst_rdata3", int'(cfg_rdata), 12'h000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = 3'b111; beat = 1'b1; last = 1'b1;
        step(1'b1, "post_rst");
        cmp_out("post_rst_first", 3'b010, 2'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
